// File: rtl/clock_time_ctrl.sv
// HH:MM:SS time-keeping controller: prescaled second ticks, BCD digit chain and set-mode FSM.
// Optional CLOCK_12H_EN build presents hours as 12h with a PM flag (time is kept as 24h).
module clock_time_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       en,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [1:0] hr_t,
  output logic [3:0] hr_u,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_pulse,
  output logic       pm
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TickW-1:0]  TickMax  = TickW'(TICK_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetHr  = 2'b01,
    StSetMin = 2'b10
  } mode_e;

  mode_e mode_q, mode_d;
  logic  mode_chg;

  // Packed BCD: hours {t[1:0], u[3:0]}, minutes/seconds {t[2:0], u[3:0]}; hours kept as 24h.
  logic [5:0]        hr_q, hr_d;
  logic [6:0]        min_q, min_d;
  logic [6:0]        sec_q, sec_d;
  logic [TickW-1:0]  psc_q, psc_d;
  logic [BlinkW-1:0] bcnt_q, bcnt_d;
  logic              blink_q, blink_d;
  logic              pulse_q;
  logic              tick;
  logic [5:0]        disp_q, disp_d;

  function automatic logic [6:0] inc60(input logic [6:0] v);
    logic [2:0] t;
    logic [3:0] u;
    t = v[6:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 3'd5) ? 3'd0 : t + 3'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [5:0] inc24(input logic [5:0] v);
    logic [1:0] t;
    logic [3:0] u;
    t = v[5:4];
    u = v[3:0];
    if (t == 2'd2 && u == 4'd3) begin
      t = 2'd0;
      u = 4'd0;
    end else if (u == 4'd9) begin
      t = t + 2'd1;
      u = 4'd0;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

`ifdef CLOCK_12H_EN
  logic pm_q, pm_d;

  // Returns {pm, tens[1:0], units[3:0]} for a 24h BCD hour.
  function automatic logic [6:0] to_12h(input logic [5:0] h24);
    logic [4:0] bin;
    logic [4:0] h12;
    logic       is_pm;
    bin   = 5'(h24[5:4]) * 5'd10 + 5'(h24[3:0]);
    is_pm = (bin >= 5'd12);
    if (bin == 5'd0) begin
      h12 = 5'd12;
    end else if (bin > 5'd12) begin
      h12 = bin - 5'd12;
    end else begin
      h12 = bin;
    end
    if (h12 >= 5'd10) begin
      return {is_pm, 2'd1, 4'(h12 - 5'd10)};
    end
    return {is_pm, 2'd0, h12[3:0]};
  endfunction
`endif

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      StRun:    if (mode_btn) mode_d = StSetHr;
      StSetHr:  if (mode_btn) mode_d = StSetMin;
      StSetMin: if (mode_btn) mode_d = StRun;
      default:  mode_d = StRun;
    endcase
    mode_chg = (mode_d != mode_q);
  end

  // A mode change takes priority over both ticks and inc on the same edge.
  always_comb begin
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    psc_d   = psc_q;
    tick    = 1'b0;
    blink_d = 1'b0;
    bcnt_d  = '0;
    if (mode_chg) begin
      psc_d   = '0;
      blink_d = (mode_d != StRun);
      if (mode_d == StSetHr) begin
        sec_d = '0;
      end
    end else begin
      case (mode_q)
        StRun: begin
          if (en) begin
            if (psc_q == TickMax) begin
              psc_d = '0;
              tick  = 1'b1;
            end else begin
              psc_d = psc_q + TickW'(1);
            end
          end
        end
        StSetHr:  if (inc_btn) hr_d = inc24(hr_q);
        StSetMin: if (inc_btn) min_d = inc60(min_q);
        default: ;
      endcase
      if (mode_q != StRun) begin
        if (bcnt_q == BlinkMax) begin
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
          bcnt_d  = bcnt_q + BlinkW'(1);
        end
      end
    end
    if (tick) begin
      if (sec_q == 7'h59) begin
        sec_d = '0;
        if (min_q == 7'h59) begin
          min_d = '0;
          hr_d  = inc24(hr_q);
        end else begin
          min_d = inc60(min_q);
        end
      end else begin
        sec_d = inc60(sec_q);
      end
    end
  end

`ifdef CLOCK_12H_EN
  always_comb begin
    {pm_d, disp_d} = to_12h(hr_d);
  end
`else
  always_comb begin
    disp_d = hr_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      mode_q  <= StRun;
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      psc_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      pulse_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      psc_q   <= psc_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      pulse_q <= tick;
      disp_q  <= disp_d;
    end
  end

`ifdef CLOCK_12H_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  assign hr_t      = disp_q[5:4];
  assign hr_u      = disp_q[3:0];
  assign min_t     = min_q[6:4];
  assign min_u     = min_q[3:0];
  assign sec_t     = sec_q[6:4];
  assign sec_u     = sec_q[3:0];
  assign mode      = mode_q;
  assign blink     = blink_q;
  assign sec_pulse = pulse_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: directed scenarios plus random stimulus against a
// seconds-of-day reference model, checked after every clock edge.
module tb_clock_time_ctrl;

  localparam int TickDiv  = 4;
  localparam int BlinkDiv = 3;

  logic       clock = 1'b0;
  logic       clear, en, mode_btn, inc_btn;
  logic [1:0] hr_t;
  logic [3:0] hr_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic [1:0] mode;
  logic       blink, sec_pulse, pm;

  clock_time_ctrl #(
    .TICK_DIV (TickDiv),
    .BLINK_DIV(BlinkDiv)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .en       (en),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .hr_t     (hr_t),
    .hr_u     (hr_u),
    .min_t    (min_t),
    .min_u    (min_u),
    .sec_t    (sec_t),
    .sec_u    (sec_u),
    .mode     (mode),
    .blink    (blink),
    .sec_pulse(sec_pulse),
    .pm       (pm)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time as seconds of day, mode 0/1/2, plain counters.
  int m_t = 0, m_mode = 0, m_pc = 0, m_bc = 0, m_blink = 0, m_pulse = 0, m_clr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int h, mi, s;
    if (clear) begin
      m_t = 0; m_mode = 0; m_pc = 0; m_bc = 0; m_blink = 0; m_pulse = 0; m_clr = 1;
    end else begin
      m_clr   = 0;
      m_pulse = 0;
      if (mode_btn) begin
        m_mode  = (m_mode + 1) % 3;
        m_pc    = 0;
        m_bc    = 0;
        m_blink = (m_mode != 0);
        if (m_mode == 1) m_t = m_t - (m_t % 60);
      end else if (m_mode == 0) begin
        m_blink = 0;
        if (en) begin
          m_pc++;
          if (m_pc == TickDiv) begin
            m_pc    = 0;
            m_t     = (m_t + 1) % 86400;
            m_pulse = 1;
          end
        end
      end else begin
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        if (inc_btn) begin
          if (m_mode == 1) h = (h + 1) % 24;
          else mi = (mi + 1) % 60;
        end
        m_t = h * 3600 + mi * 60 + s;
        m_bc++;
        if (m_bc == BlinkDiv) begin
          m_bc    = 0;
          m_blink = !m_blink;
        end
      end
    end
  endtask

  function automatic int exp_hours();
    int h;
    h = m_t / 3600;
    if (m_clr != 0) return 0;
`ifdef CLOCK_12H_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
`endif
    return h;
  endfunction

  function automatic int exp_pm();
`ifdef CLOCK_12H_EN
    if (m_clr == 0 && m_t / 3600 >= 12) return 1;
`endif
    return 0;
  endfunction

  task automatic compare_all();
    logic ok;
    ok = (sec_u <= 4'd9) && (sec_t <= 3'd5) && (min_u <= 4'd9) && (min_t <= 3'd5) &&
         (hr_u <= 4'd9) && (hr_t <= 2'd2) && !(hr_t == 2'd2 && hr_u > 4'd3);
    check("bcd_valid", 32'(ok), 1);
    check("hours", 32'(hr_t) * 10 + 32'(hr_u), exp_hours());
    check("minutes", 32'(min_t) * 10 + 32'(min_u), (m_t / 60) % 60);
    check("seconds", 32'(sec_t) * 10 + 32'(sec_u), m_t % 60);
    check("mode", 32'(mode), m_mode);
    check("blink", 32'(blink), m_blink);
    check("sec_pulse", 32'(sec_pulse), m_pulse);
    check("pm", 32'(pm), exp_pm());
  endtask

  task automatic cycle(input logic c, input logic e, input logic mb, input logic ib);
    clear    = c;
    en       = e;
    mode_btn = mb;
    inc_btn  = ib;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic int dut_secs();
    return int'(sec_t) * 10 + int'(sec_u);
  endfunction

  initial begin
    int last, pulses;
    clear = 1'b1; en = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;

    // Reset, including with other inputs active.
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    check("rst_sec", dut_secs(), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_pm", 32'(pm), 0);

    // 40 enabled cycles: ten one-cycle pulses, four apart.
    last = 0; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(0, 1, 0, 0);
      if (sec_pulse) begin
        if (pulses > 0) check("pulse_gap", i - last, TickDiv);
        pulses++;
        last = i;
      end
    end
    check("pulse_count", pulses, 10);
    check("sec_after_40", dut_secs(), 10);

    // Freeze mid-phase with en=0, then resume with the same phase.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    check("frozen_sec", dut_secs(), 10);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("resumed_sec", dut_secs(), 11);

    // Set 23:59 with wraps in both set fields and a simultaneous mode+inc.
    cycle(0, 1, 1, 0);
    check("set_hr_sec_zero", dut_secs(), 0);
    for (int i = 0; i < 23; i++) cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    for (int i = 0; i < 23; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 1, 1);
    check("mode_wins", 32'(mode), 2);
    for (int i = 0; i < 59; i++) cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    check("min_wrap", 32'(min_t) * 10 + 32'(min_u), 0);
    for (int i = 0; i < 59; i++) cycle(0, 1, 0, 1);
    cycle(0, 1, 1, 0);
    for (int i = 0; i < 60 * TickDiv; i++) cycle(0, 1, 0, 0);
    check("midnight_min", 32'(min_t) * 10 + 32'(min_u), 0);
    check("midnight_sec", dut_secs(), 0);

    // Clear while blinking in SET_MIN.
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    check("pre_clear_blink", 32'(blink), 1);
    cycle(1, 1, 1, 1);
    check("clear_mode", 32'(mode), 0);
    check("clear_blink", 32'(blink), 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Time-keeping controller for the digital clock. It sequences the BCD digit chain HH:MM:SS from a free-running system clock through an internal prescaler.
- It also runs the set-mode FSM driven by two debounced single-cycle button pulses.
- It sits between the button conditioning logic and the display mux/7-segment decoders.

Parameters:
TICK_DIV, 50000000, system clock cycles per one-second tick (>=1)
BLINK_DIV, 12500000, cycles per half-period of the set-mode blink output (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
clear  input  1  synchronous active-high reset
en  input  1  run enable; 0 freezes prescaler and time in RUN
mode_btn  input  1  single-cycle pulse; advances mode FSM
inc_btn  input  1  single-cycle pulse; increments the field being set
hr_t  output  2  hours tens BCD
hr_u  output  4  hours units BCD
min_t  output  3  minutes tens BCD
min_u  output  4  minutes units BCD
sec_t  output  3  seconds tens BCD
sec_u  output  4  seconds units BCD
mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 unused)
blink  output  1  set-mode flash strobe for display blanking
sec_pulse  output  1  one-cycle pulse on each applied second tick
pm  output  1  PM indicator (12h build only)

Behaviour:
- Reset (clear=1 at a rising edge):
  - All digits become 0 (00:00:00). mode=RUN. Prescaler=0. Blink counter=0. blink=0. sec_pulse=0. pm=0.
  - clear dominates every other input on that edge, including mid-carry and mid-set.
- Prescaler:
  - Counts 0..TICK_DIV-1 only when mode=RUN and en=1, and holds its value otherwise.
  - Internal tick = (count==TICK_DIV-1) & en & RUN. On that edge the count wraps to 0.
  - TICK_DIV=1 gives a tick on every enabled cycle.
- Tick (registered, same edge):
  - sec_u increments; 9 wraps to 0 with carry to sec_t.
  - sec_t 5 with carry wraps to 0 with carry to minutes. Minutes follow the same rule with carry to hours.
  - Hours 23 wraps to 00 with no further carry.
  - sec_pulse=1 for exactly the cycle following the tick edge.
  - Example: 23:59:59 plus one tick gives 00:00:00 in one edge.
- Mode FSM, advanced by mode_btn: RUN -> SET_HR -> SET_MIN -> RUN.
  - Entering SET_HR: seconds forced to 00 and prescaler to 0.
  - Leaving SET_MIN to RUN: prescaler restarts from 0, so the first tick comes TICK_DIV enabled cycles later.
  - Mode transitions ignore en.
- inc_btn:
  - SET_HR: hours +1 mod 24, no effect on minutes.
  - SET_MIN: minutes +1 mod 60, with no carry into hours (59 -> 00, hours unchanged).
  - RUN: ignored.
- Simultaneous mode_btn and inc_btn: the mode advance wins and the inc is dropped.
- No ticks are applied in SET states. The time in SET states changes only through inc.
- blink:
  - In SET states it toggles every BLINK_DIV cycles, starting at 1 on SET entry; the counter restarts on every mode change.
  - In RUN, blink=0.
- All outputs are registered. The digits are always valid BCD within their range.

Optional Feature:
Macro CLOCK_12H_EN:
- Defined: time is still kept internally in 24h form. The registered hour outputs are remapped 0 -> 12 and 13..23 -> 1..11. pm=1 for internal hours 12..23. SET_HR inc steps through internal hours, so the display goes 12AM,1AM..11AM,12PM..11PM and then wraps.
- Not defined: hours are presented as 00..23 and pm is tied to 0.

Test Plan:
- TICK_DIV=4, clear pulse, en=1 for 40 cycles -> digits 00:00:10; sec_pulse asserted 10 times, each 1 cycle wide, 4 cycles apart.
- Preset via SET_HR/SET_MIN to 23:59, return to RUN, 60 ticks -> exactly 00:00:00 after the 60th tick edge; no intermediate invalid BCD.
- en=0 for 20 cycles in RUN at 00:00:05 -> digits and prescaler frozen; en=1 resumes with the same phase.
- In SET_MIN at 12:59, inc_btn -> 12:00 (hours unchanged). In SET_HR at 23, inc_btn -> 00. mode_btn together with inc_btn in SET_HR -> mode=SET_MIN, hours unchanged.
- clear asserted during SET_MIN with blink=1 -> next cycle mode=RUN, 00:00:00, blink=0, pm=0.
- CLOCK_12H_EN defined, internal 00:xx -> hr 12 pm=0; internal 13:xx -> hr 01 pm=1; internal 12:xx -> hr 12 pm=1.
